// File: rtl/pipe_hazard_unit_pkg.sv
// Shared widths, forward-select encoding and MD latency defaults for the hazard unit.
package pipe_hazard_unit_pkg;
   localparam int RA_W         = 5;
   localparam int FWD_GRF      = 0;
   localparam int DEF_MULT_LAT = 5;
   localparam int DEF_DIV_LAT  = 10;

   typedef logic [RA_W-1:0] reg_addr_t;

   // Select width: 0 = GRF plus one code per tracked stage.
   function automatic int fwd_sel_w(input int stages);
      return $clog2(stages + 1);
   endfunction
endpackage

// File: rtl/pipe_hazard_unit_if.sv
// D-stage hazard query and stall/forward answer between datapath and hazard unit.
interface pipe_hazard_unit_if #(
   parameter int NUM_RD = 2,
   parameter int STAGES = 3,
   parameter int TW     = 2
);
   import pipe_hazard_unit_pkg::*;
   localparam int SW = fwd_sel_w(STAGES);

   reg_addr_t [NUM_RD-1:0]                  d_ra;
   logic      [NUM_RD-1:0][TW-1:0]          d_tuse;
   logic                                    d_we;
   reg_addr_t                               d_wa;
   logic      [TW-1:0]                      d_tnew;
   logic                                    d_md_start;
   logic                                    d_md_div;
   logic                                    d_md_use;
   logic                                    stall;
   logic      [NUM_RD-1:0][SW-1:0]          d_fwd_sel;
   logic      [STAGES-1:0][NUM_RD-1:0][SW-1:0] stg_fwd_sel;
   logic                                    md_busy;

   modport master (
      output d_ra, d_tuse, d_we, d_wa, d_tnew, d_md_start, d_md_div, d_md_use,
      input  stall, d_fwd_sel, stg_fwd_sel, md_busy
   );
   modport slave (
      input  d_ra, d_tuse, d_we, d_wa, d_tnew, d_md_start, d_md_div, d_md_use,
      output stall, d_fwd_sel, stg_fwd_sel, md_busy
   );
endinterface

// File: rtl/hazard_md_counter.sv
// MULT/DIV busy counter: loads the op latency on start, counts down to idle.
module hazard_md_counter #(
   parameter int MULT_LAT = 5,
   parameter int DIV_LAT  = 10
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic div,
   output logic busy
);
   localparam int CW = $clog2(DIV_LAT + 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset)
         cnt <= '0;
      else if (start)
         cnt <= div ? CW'(DIV_LAT) : CW'(MULT_LAT);
      else if (cnt != '0)
         cnt <= cnt - CW'(1);
   end

   assign busy = (cnt != '0);
endmodule

// File: rtl/pipe_hazard_unit.sv
// Stall/forward controller: tracks E..W writers in its own scoreboard and
// resolves D-stage and per-stage operand sources, plus HI/LO busy stalls.
module pipe_hazard_unit
   import pipe_hazard_unit_pkg::*;
#(
   parameter int NUM_RD   = 2,
   parameter int STAGES   = 3,
   parameter int TW       = 2,
   parameter int MULT_LAT = DEF_MULT_LAT,
   parameter int DIV_LAT  = DEF_DIV_LAT
) (
   input logic               clk,
   input logic               reset,
   pipe_hazard_unit_if.slave hz
);
   localparam int SW = fwd_sel_w(STAGES);

   typedef struct packed {
      reg_addr_t     wa;
      logic          we;
      logic [TW-1:0] tnew;
   } entry_t;

   entry_t [STAGES-1:0]                         sb;
   // Read addresses are only consulted by stages that still have older stages behind them.
   logic   [STAGES-2:0][NUM_RD-1:0][RA_W-1:0]   sb_ra;
   logic                                        e0_md;
   logic   [NUM_RD-1:0]                         port_stall;
   logic                                        md_busy_w;
   logic                                        stall;

   function automatic logic hit(input entry_t e, input reg_addr_t ra);
      return e.we && (e.wa == ra) && (ra != '0);
   endfunction

   function automatic entry_t age(input entry_t e);
      entry_t a;
      a = e;
      if (a.tnew != '0) a.tnew = a.tnew - TW'(1);
      return a;
   endfunction

   // D operands: first match from E upward decides, older writers never considered.
   for (genvar p = 0; p < NUM_RD; p++) begin : g_dport
      logic [SW-1:0] sel;
      logic          stl;
      always_comb begin
         logic found;
         found = 1'b0;
         sel   = SW'(FWD_GRF);
         stl   = 1'b0;
         for (int s = 0; s < STAGES; s++) begin
            if (!found && hit(sb[s], hz.d_ra[p])) begin
               found = 1'b1;
               stl   = sb[s].tnew > hz.d_tuse[p];
               if (sb[s].tnew == '0) sel = SW'(s + 1);
            end
         end
      end
      assign hz.d_fwd_sel[p] = sel;
      assign port_stall[p]   = stl;
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stg
      for (genvar p = 0; p < NUM_RD; p++) begin : g_port
         logic [SW-1:0] sel;
         if (k < STAGES - 1) begin : g_scan
            always_comb begin
               logic found;
               found = 1'b0;
               sel   = SW'(FWD_GRF);
               for (int j = k + 1; j < STAGES; j++) begin
                  if (!found && hit(sb[j], sb_ra[k][p])) begin
                     found = 1'b1;
                     if (sb[j].tnew == '0) sel = SW'(j + 1);
                  end
               end
            end
         end else begin : g_last
            assign sel = SW'(FWD_GRF);
         end
         assign hz.stg_fwd_sel[k][p] = sel;
      end
   end

   // A just-issued mult/div in E counts as busy even before the counter is visible.
   assign stall = (|port_stall) || (hz.d_md_use && (md_busy_w || e0_md));

   always_ff @(posedge clk) begin
      if (reset) begin
         sb    <= '0;
         sb_ra <= '0;
         e0_md <= 1'b0;
      end else begin
         for (int s = 1; s < STAGES; s++)     sb[s]    <= age(sb[s-1]);
         for (int s = 1; s < STAGES - 1; s++) sb_ra[s] <= sb_ra[s-1];
         if (stall) begin
            sb[0]    <= '0;
            sb_ra[0] <= '0;
            e0_md    <= 1'b0;
         end else begin
            sb[0].wa   <= hz.d_wa;
            sb[0].we   <= hz.d_we;
            sb[0].tnew <= hz.d_tnew;
            sb_ra[0]   <= hz.d_ra;
            e0_md      <= hz.d_md_start;
         end
      end
   end

   hazard_md_counter #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) u_md (
      .clk   (clk),
      .reset (reset),
      .start (hz.d_md_start && !stall),
      .div   (hz.d_md_div),
      .busy  (md_busy_w)
   );

   assign hz.stall   = stall;
   assign hz.md_busy = md_busy_w;
endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed bench for pipe_hazard_unit: hand-derived expectations queued per step.
module tb_pipe_hazard_unit;
   localparam int NUM_RD = 2;
   localparam int STAGES = 3;
   localparam int TW     = 2;
   localparam int SW     = 2;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   pipe_hazard_unit_if #(.NUM_RD(NUM_RD), .STAGES(STAGES), .TW(TW)) hz ();

   pipe_hazard_unit #(
      .NUM_RD(NUM_RD), .STAGES(STAGES), .TW(TW), .MULT_LAT(5), .DIV_LAT(10)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .hz    (hz)
   );

   typedef struct packed {
      logic                                   stall;
      logic [NUM_RD-1:0][SW-1:0]              dsel;
      logic [STAGES-1:0][NUM_RD-1:0][SW-1:0]  ssel;
      logic                                   busy;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic drive(input logic [4:0] ra0, input logic [4:0] ra1,
                        input logic [1:0] tu0, input logic [1:0] tu1,
                        input logic we, input logic [4:0] wa, input logic [1:0] tnew,
                        input logic mds, input logic mdd, input logic mdu);
      hz.d_ra[0]     = ra0;
      hz.d_ra[1]     = ra1;
      hz.d_tuse[0]   = tu0;
      hz.d_tuse[1]   = tu1;
      hz.d_we        = we;
      hz.d_wa        = wa;
      hz.d_tnew      = tnew;
      hz.d_md_start  = mds;
      hz.d_md_div    = mdd;
      hz.d_md_use    = mdu;
   endtask

   task automatic idle();
      drive(5'd0, 5'd0, 2'd3, 2'd3, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic flush();
      idle();
      repeat (3) tick();
   endtask

   task automatic exp_push(input logic st, input logic [1:0] d0, input logic [1:0] d1,
                           input logic [1:0] s00, input logic [1:0] s01,
                           input logic [1:0] s10, input logic [1:0] s11, input logic bz);
      exp_t e;
      e          = '0;
      e.stall    = st;
      e.dsel[0]  = d0;
      e.dsel[1]  = d1;
      e.ssel[0][0] = s00;
      e.ssel[0][1] = s01;
      e.ssel[1][0] = s10;
      e.ssel[1][1] = s11;
      e.busy     = bz;
      exp_q.push_back(e);
   endtask

   task automatic check(input string tag);
      exp_t e;
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      assert (hz.stall === e.stall) else begin
         n_bad++;
         $error("FAIL %s stall got %0b want %0b", tag, hz.stall, e.stall);
      end
      n_cmp++;
      assert (hz.d_fwd_sel === e.dsel) else begin
         n_bad++;
         $error("FAIL %s d_fwd_sel got %h want %h", tag, hz.d_fwd_sel, e.dsel);
      end
      n_cmp++;
      assert (hz.stg_fwd_sel === e.ssel) else begin
         n_bad++;
         $error("FAIL %s stg_fwd_sel got %h want %h", tag, hz.stg_fwd_sel, e.ssel);
      end
      n_cmp++;
      assert (hz.md_busy === e.busy) else begin
         n_bad++;
         $error("FAIL %s md_busy got %0b want %0b", tag, hz.md_busy, e.busy);
      end
   endtask

   task automatic step(input string tag, input logic st, input logic [1:0] d0,
                       input logic [1:0] d1, input logic [1:0] s00, input logic [1:0] s01,
                       input logic [1:0] s10, input logic [1:0] s11, input logic bz);
      exp_push(st, d0, d1, s00, s01, s10, s11, bz);
      check(tag);
      tick();
   endtask

   initial begin
      reset = 1'b1;
      idle();
      repeat (2) tick();
      reset = 1'b0;
      step("reset", 0, 0, 0, 0, 0, 0, 0, 0);

      // lw $1 then dependent add: one bubble, then E picks the value from W
      drive(5'd0, 5'd0, 2'd1, 2'd3, 1'b1, 5'd1, 2'd2, 1'b0, 1'b0, 1'b0);
      step("t1_lw", 0, 0, 0, 0, 0, 0, 0, 0);
      drive(5'd1, 5'd3, 2'd1, 2'd1, 1'b1, 5'd2, 2'd1, 1'b0, 1'b0, 1'b0);
      step("t1_stall", 1, 0, 0, 0, 0, 0, 0, 0);
      step("t1_resume", 0, 0, 0, 0, 0, 0, 0, 0);
      idle();
      step("t1_e_fwd", 0, 0, 0, 3, 0, 0, 0, 0);
      flush();

      // addu $1 then beq $1,$0
      drive(5'd0, 5'd0, 2'd3, 2'd3, 1'b1, 5'd1, 2'd1, 1'b0, 1'b0, 1'b0);
      step("t2_addu", 0, 0, 0, 0, 0, 0, 0, 0);
      drive(5'd1, 5'd0, 2'd0, 2'd0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
      step("t2_stall", 1, 0, 0, 0, 0, 0, 0, 0);
      step("t2_fwd_m", 0, 2, 0, 0, 0, 0, 0, 0);
      flush();

      // two writers of $4: youngest wins everywhere
      drive(5'd0, 5'd0, 2'd3, 2'd3, 1'b1, 5'd4, 2'd1, 1'b0, 1'b0, 1'b0);
      step("t3_a1", 0, 0, 0, 0, 0, 0, 0, 0);
      step("t3_a2", 0, 0, 0, 0, 0, 0, 0, 0);
      drive(5'd4, 5'd4, 2'd1, 2'd1, 1'b1, 5'd5, 2'd1, 1'b0, 1'b0, 1'b0);
      step("t3_sub", 0, 0, 0, 0, 0, 0, 0, 0);
      drive(5'd4, 5'd0, 2'd0, 2'd0, 1'b1, 5'd7, 2'd1, 1'b0, 1'b0, 1'b0);
      step("t3_or", 0, 2, 0, 2, 2, 0, 0, 0);
      idle();
      step("t3_deep", 0, 0, 0, 3, 0, 3, 3, 0);
      flush();

      // writes to $0 never create hazards
      drive(5'd0, 5'd0, 2'd3, 2'd3, 1'b1, 5'd0, 2'd1, 1'b0, 1'b0, 1'b0);
      step("t4_ori", 0, 0, 0, 0, 0, 0, 0, 0);
      drive(5'd0, 5'd0, 2'd0, 2'd0, 1'b1, 5'd6, 2'd1, 1'b0, 1'b0, 1'b0);
      step("t4_add", 0, 0, 0, 0, 0, 0, 0, 0);
      idle();
      step("t4_e", 0, 0, 0, 0, 0, 0, 0, 0);
      flush();

      // mult then mfhi: stalled for MULT_LAT cycles
      drive(5'd0, 5'd0, 2'd3, 2'd3, 1'b0, 5'd0, 2'd0, 1'b1, 1'b0, 1'b1);
      step("t5_mult", 0, 0, 0, 0, 0, 0, 0, 0);
      drive(5'd0, 5'd0, 2'd3, 2'd3, 1'b1, 5'd8, 2'd1, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) step("t5_mult_wait", 1, 0, 0, 0, 0, 0, 0, 1);
      step("t5_mult_go", 0, 0, 0, 0, 0, 0, 0, 0);
      flush();

      drive(5'd0, 5'd0, 2'd3, 2'd3, 1'b0, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1);
      step("t5_div", 0, 0, 0, 0, 0, 0, 0, 0);
      drive(5'd0, 5'd0, 2'd3, 2'd3, 1'b1, 5'd8, 2'd1, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 10; i++) step("t5_div_wait", 1, 0, 0, 0, 0, 0, 0, 1);
      step("t5_div_go", 0, 0, 0, 0, 0, 0, 0, 0);
      flush();

      // reset during a div with a pending load writer
      drive(5'd0, 5'd0, 2'd3, 2'd3, 1'b0, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1);
      step("t6_div", 0, 0, 0, 0, 0, 0, 0, 0);
      idle();
      step("t6_busy1", 0, 0, 0, 0, 0, 0, 0, 1);
      drive(5'd0, 5'd0, 2'd3, 2'd3, 1'b1, 5'd9, 2'd2, 1'b0, 1'b0, 1'b0);
      step("t6_busy2", 0, 0, 0, 0, 0, 0, 0, 1);
      idle();
      reset = 1'b1;
      step("t6_rst", 0, 0, 0, 0, 0, 0, 0, 1);
      reset = 1'b0;
      drive(5'd9, 5'd0, 2'd0, 2'd3, 1'b1, 5'd10, 2'd1, 1'b0, 1'b0, 1'b1);
      step("t6_after", 0, 0, 0, 0, 0, 0, 0, 0);
      flush();

      // reset and start in the same cycle: counter stays idle
      reset = 1'b1;
      drive(5'd0, 5'd0, 2'd3, 2'd3, 1'b0, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1);
      step("t7_rst_start", 0, 0, 0, 0, 0, 0, 0, 0);
      reset = 1'b0;
      drive(5'd0, 5'd0, 2'd3, 2'd3, 1'b1, 5'd8, 2'd1, 1'b0, 1'b0, 1'b1);
      step("t7_mfhi", 0, 0, 0, 0, 0, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
